// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and the minimum bit-period divisor.
package uart_pkg;

  localparam int unsigned MIN_DIV = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous bit; both flops reset to 1 (line idle).
module uart_sync2 (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic meta_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      meta_q <= 1'b1;
      o_q    <= 1'b1;
    end else begin
      meta_q <= i_d;
      o_q    <= meta_q;
    end
  end

endmodule

// File: rtl/uart_rx_ext.sv
// UART receiver with runtime divisor, ready/valid output and error pulses.
// Optional parity bit checking is enabled by defining UART_RX_PARITY_EN.
module uart_rx_ext
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [DIV_W-1:0]     i_clk_per_bit,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_frame_err,
  output logic                 o_parity_err,
  output logic                 o_overrun
);

  localparam int unsigned BIT_CNT_W = 4;

  if (DATA_BITS < 5 || DATA_BITS > 9 || (STOP_BITS != 1 && STOP_BITS != 2) || PARITY_ODD > 1)
  begin : g_cfg_check
    $error("uart_rx_ext: illegal parameter combination");
  end

  logic                 rx_s;
  rx_state_e            state_q, state_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [DIV_W-1:0]     cnt_q, cnt_d;
  logic [BIT_CNT_W-1:0] bit_q, bit_d;
  logic                 stop_idx_q, stop_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 stop_bad_q, stop_bad_d;
  logic                 par_bad_q, par_bad_d;
  logic [DATA_BITS-1:0] data_d;
  logic                 valid_d, ferr_d, ovr_d;
  logic                 sample_c, bit_end_c, done_c, frame_bad_c, par_fail_c;

  uart_sync2 u_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_rx),
    .o_q   (rx_s)
  );

  assign sample_c  = (cnt_q == (div_q >> 1));
  assign bit_end_c = (cnt_q == (div_q - DIV_W'(1)));

`ifdef UART_RX_PARITY_EN
  localparam logic PAR_ODD = 1'(PARITY_ODD);
  logic perr_d;
  assign par_fail_c = par_bad_q;
  assign perr_d     = done_c & par_bad_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) o_parity_err <= 1'b0;
    else       o_parity_err <= perr_d;
  end
`else
  assign par_fail_c   = 1'b0;
  assign o_parity_err = 1'b0;
`endif

  // Frame sequencing; stop bit finishes at its sample so a following start edge is not missed.
  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    cnt_d       = cnt_q + DIV_W'(1);
    bit_d       = bit_q;
    stop_idx_d  = stop_idx_q;
    shift_d     = shift_q;
    stop_bad_d  = stop_bad_q;
    par_bad_d   = par_bad_q;
    done_c      = 1'b0;
    frame_bad_c = stop_bad_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) begin
          div_d      = (i_clk_per_bit < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : i_clk_per_bit;
          bit_d      = '0;
          stop_idx_d = 1'b0;
          stop_bad_d = 1'b0;
          par_bad_d  = 1'b0;
          state_d    = START;
        end
      end
      START: begin
        if (sample_c && rx_s) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (bit_end_c) begin
          cnt_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (sample_c) begin
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          bit_d   = bit_q + BIT_CNT_W'(1);
        end
        if (bit_end_c) begin
          cnt_d = '0;
          if (bit_q == BIT_CNT_W'(DATA_BITS)) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (sample_c) par_bad_d = ((^shift_q) ^ rx_s) != PAR_ODD;
        if (bit_end_c) begin
          cnt_d   = '0;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (sample_c) begin
          if (!rx_s) stop_bad_d = 1'b1;
          if (stop_idx_q == 1'(STOP_BITS - 1)) begin
            done_c      = 1'b1;
            frame_bad_c = stop_bad_q | ~rx_s;
            cnt_d       = '0;
            state_d     = IDLE;
          end
        end else if (bit_end_c) begin
          cnt_d      = '0;
          stop_idx_d = 1'b1;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Output holding register: handshake clears, a good frame loads or overruns.
  always_comb begin
    data_d  = o_data;
    valid_d = o_valid;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
    if (o_valid && i_ready) valid_d = 1'b0;
    if (done_c) begin
      ferr_d = frame_bad_c;
      if (!frame_bad_c && !par_fail_c) begin
        if (o_valid && !i_ready) begin
          ovr_d = 1'b1;
        end else begin
          data_d  = shift_q;
          valid_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      div_q       <= '0;
      cnt_q       <= '0;
      bit_q       <= '0;
      stop_idx_q  <= 1'b0;
      shift_q     <= '0;
      stop_bad_q  <= 1'b0;
      par_bad_q   <= 1'b0;
      o_data      <= '0;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      stop_idx_q  <= stop_idx_d;
      shift_q     <= shift_d;
      stop_bad_q  <= stop_bad_d;
      par_bad_q   <= par_bad_d;
      o_data      <= data_d;
      o_valid     <= valid_d;
      o_frame_err <= ferr_d;
      o_overrun   <= ovr_d;
    end
  end

endmodule

// File: tb/tb_uart_rx_ext.sv
// Self-checking bench for uart_rx_ext: frame-level event model plus directed literal checks.
module tb_uart_rx_ext;

  localparam int unsigned DB   = 8;
  localparam int unsigned SB   = 1;
  localparam int unsigned DW   = 16;
  localparam int unsigned PODD = 0;
`ifdef UART_RX_PARITY_EN
  localparam int unsigned PB = 1;
`else
  localparam int unsigned PB = 0;
`endif

  typedef struct {
    int unsigned cyc;
    bit          good;
    bit          ferr;
    bit          perr;
    logic [7:0]  data;
  } ev_t;

  logic          clk = 1'b0;
  logic          i_rst;
  logic [DW-1:0] i_clk_per_bit;
  logic          i_rx;
  logic          i_ready;
  logic [DB-1:0] o_data;
  logic          o_valid, o_frame_err, o_parity_err, o_overrun;

  int unsigned cyc = 0;
  logic        rdy_e, rst_e;
  int          n_checks = 0;
  int          n_fail = 0;
  int          n_ferr = 0, n_perr = 0, n_ovr = 0;
  int          rdy_mode = 2;
  ev_t         evq[$];
  logic        exp_valid = 1'b0;
  logic [7:0]  exp_data = 8'h00;

  uart_rx_ext #(.DATA_BITS(DB), .STOP_BITS(SB), .DIV_W(DW), .PARITY_ODD(PODD)) dut (
    .i_clk         (clk),
    .i_rst         (i_rst),
    .i_clk_per_bit (i_clk_per_bit),
    .i_rx          (i_rx),
    .o_data        (o_data),
    .o_valid       (o_valid),
    .i_ready       (i_ready),
    .o_frame_err   (o_frame_err),
    .o_parity_err  (o_parity_err),
    .o_overrun     (o_overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rdy_e <= i_ready;
    rst_e <= i_rst;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: apply the frame outcome scheduled for this edge, then compare every output.
  always @(negedge clk) begin
    logic exp_ferr, exp_perr, exp_ovr, hs, loaded;
    ev_t  ev;
    exp_ferr = 1'b0;
    exp_perr = 1'b0;
    exp_ovr  = 1'b0;
    loaded   = 1'b0;
    if (rst_e === 1'b1) begin
      exp_valid = 1'b0;
      exp_data  = 8'h00;
      evq.delete();
    end else begin
      hs = exp_valid && rdy_e;
      if (evq.size() > 0 && evq[0].cyc <= cyc) begin
        ev = evq.pop_front();
        chk("event_schedule", 32'(cyc), 32'(ev.cyc));
        exp_ferr = ev.ferr;
        exp_perr = ev.perr;
        if (ev.good) begin
          if (exp_valid && !rdy_e) exp_ovr = 1'b1;
          else begin
            exp_data  = ev.data;
            exp_valid = 1'b1;
            loaded    = 1'b1;
          end
        end
      end
      if (hs && !loaded) exp_valid = 1'b0;
    end
    if (cyc >= 1) begin
      chk("o_valid", 32'(o_valid), 32'(exp_valid));
      chk("o_data", 32'(o_data), 32'(exp_data));
      chk("o_frame_err", 32'(o_frame_err), 32'(exp_ferr));
      chk("o_parity_err", 32'(o_parity_err), 32'(exp_perr));
      chk("o_overrun", 32'(o_overrun), 32'(exp_ovr));
    end
    n_ferr += int'(o_frame_err === 1'b1);
    n_perr += int'(o_parity_err === 1'b1);
    n_ovr  += int'(o_overrun === 1'b1);
  end

  initial begin
    i_ready = 1'b0;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0:       i_ready = 1'($urandom_range(0, 1));
        1:       i_ready = 1'b0;
        default: i_ready = 1'b1;
      endcase
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Drives one frame; abort_bit >= 0 stops mid-way through that frame bit with no outcome expected.
  task automatic send_frame(input logic [7:0] data, input int unsigned raw_div,
                            input bit stop_bad, input bit par_bad, input int abort_bit);
    int unsigned div, h, nbits;
    logic [15:0] fb;
    ev_t ev;
    div   = (raw_div < 4) ? 4 : raw_div;
    h     = div / 2;
    nbits = 1 + DB + PB + SB;
    fb    = '1;
    fb[0] = 1'b0;
    for (int i = 0; i < int'(DB); i++) fb[1+i] = data[i];
    if (PB == 1) fb[1+DB] = (^data) ^ 1'(PODD) ^ par_bad;
    for (int s = 0; s < int'(SB); s++) fb[1+DB+PB+s] = !(stop_bad && s == 0);
    if (abort_bit < 0) begin
      ev.cyc  = cyc + 1 + (nbits - 1) * div + h + 3;
      ev.perr = (PB == 1) && par_bad;
      ev.ferr = stop_bad;
      ev.good = !ev.ferr && !ev.perr;
      ev.data = data;
      evq.push_back(ev);
    end
    i_clk_per_bit = DW'(raw_div);
    for (int k = 0; k < int'(nbits); k++) begin
      i_rx = fb[k];
      if (k == int'(nbits) - 1) i_clk_per_bit = DW'(raw_div);
      for (int j = 0; j < int'(div); j++) begin
        if (k == abort_bit && j == int'(h)) return;
        @(negedge clk);
        if (k == 0 && j == 2) i_clk_per_bit = DW'($urandom);
      end
    end
    i_rx = 1'b1;
  endtask

  initial begin
    int f0, o0, p0;
    i_rst = 1'b1;
    i_rx = 1'b1;
    i_clk_per_bit = DW'(16);
    rdy_mode = 2;
    settle(3);
    chk("reset_valid", 32'(o_valid), 32'h0);
    chk("reset_data", 32'(o_data), 32'h0);
    chk("reset_ferr", 32'(o_frame_err), 32'h0);
    chk("reset_ovr", 32'(o_overrun), 32'h0);
    i_rst = 1'b0;
    settle(5);

    // Basic word held until accepted
    rdy_mode = 1;
    f0 = n_ferr;
    send_frame(8'hA5, 16, 1'b0, 1'b0, -1);
    settle(4);
    chk("a5_data", 32'(o_data), 32'hA5);
    chk("a5_valid", 32'(o_valid), 32'h1);
    chk("a5_no_ferr", 32'(n_ferr - f0), 32'h0);
    rdy_mode = 2;
    settle(3);
    chk("a5_accepted", 32'(o_valid), 32'h0);

    // Short glitch is a false start
    f0 = n_ferr;
    i_rx = 1'b0;
    settle(3);
    i_rx = 1'b1;
    settle(48);
    chk("glitch_no_valid", 32'(o_valid), 32'h0);
    chk("glitch_no_ferr", 32'(n_ferr - f0), 32'h0);
    rdy_mode = 1;
    send_frame(8'h3C, 16, 1'b0, 1'b0, -1);
    settle(4);
    chk("3c_data", 32'(o_data), 32'h3C);
    rdy_mode = 2;
    settle(3);

    // Bad stop bit
    f0 = n_ferr;
    send_frame(8'h55, 16, 1'b1, 1'b0, -1);
    settle(48);
    chk("55_ferr_once", 32'(n_ferr - f0), 32'h1);
    chk("55_no_valid", 32'(o_valid), 32'h0);

    // Overrun on back-to-back frames
    rdy_mode = 1;
    o0 = n_ovr;
    send_frame(8'h11, 16, 1'b0, 1'b0, -1);
    send_frame(8'h22, 16, 1'b0, 1'b0, -1);
    settle(20);
    chk("ovr_keeps_old", 32'(o_data), 32'h11);
    chk("ovr_once", 32'(n_ovr - o0), 32'h1);
    rdy_mode = 2;
    settle(3);
    chk("ovr_drained", 32'(o_valid), 32'h0);

`ifdef UART_RX_PARITY_EN
    p0 = n_perr;
    rdy_mode = 1;
    send_frame(8'h07, 16, 1'b0, 1'b1, -1);
    settle(20);
    chk("par_err_once", 32'(n_perr - p0), 32'h1);
    chk("par_err_no_valid", 32'(o_valid), 32'h0);
    send_frame(8'h07, 16, 1'b0, 1'b0, -1);
    settle(20);
    chk("par_ok_data", 32'(o_data), 32'h07);
    rdy_mode = 2;
    settle(3);
`else
    p0 = n_perr;
`endif

    // Reset in the middle of data bit 4
    rdy_mode = 1;
    send_frame(8'hF0, 16, 1'b0, 1'b0, 5);
    i_rst = 1'b1;
    i_rx = 1'b1;
    settle(3);
    i_rst = 1'b0;
    settle(5);
    send_frame(8'h81, 5, 1'b0, 1'b0, -1);
    settle(10);
    chk("rst_81_data", 32'(o_data), 32'h81);
    chk("rst_81_valid", 32'(o_valid), 32'h1);
    rdy_mode = 2;
    settle(3);

    // Randomized frames, divisors (including values below 4) and consumer behaviour
    for (int i = 0; i < 40; i++) begin
      logic [7:0]  d;
      int unsigned rd, eff;
      bit          sbad, pbad;
      d    = 8'($urandom);
      rd   = $urandom_range(0, 12);
      eff  = (rd < 4) ? 4 : rd;
      sbad = ($urandom_range(0, 5) == 0);
      pbad = (PB == 1) && ($urandom_range(0, 4) == 0);
      rdy_mode = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
      send_frame(d, rd, sbad, pbad, -1);
      if (sbad) settle(int'(3 * eff));
      else      settle(int'($urandom_range(0, 2) * eff));
    end
    rdy_mode = 2;
    settle(40);
    chk("queue_drained", 32'(evq.size()), 32'h0);
    chk("final_valid", 32'(o_valid), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
